// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with 2-flop synchroniser, false-start
//            rejection and framing-error detection. Define UART_RX_PARITY_EN
//            for 8E1 frames with parity checking.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
   parameter int CLKS_PER_BIT = 625
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       serial_rx,
   output logic [7:0] incoming,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] c_half_m1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] c_bit_end = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic            r_sync1;
   logic            r_sync2;
   logic            w_rx_s;
`ifdef UART_RX_PARITY_EN
   logic            r_par_bad;
`endif

   assign w_rx_s = r_sync2;
   assign busy   = (r_state != S_IDLE);

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         incoming   <= 8'h00;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
         r_par_bad  <= 1'b0;
`endif
      end else begin
         r_sync1    <= serial_rx;
         r_sync2    <= r_sync1;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
               end
            end
            S_START: begin
               if (r_cnt == c_half_m1) begin
                  // A start bit that is high again at mid-bit was a glitch.
                  if (!w_rx_s) begin
                     r_state   <= S_DATA;
                     r_cnt     <= '0;
                     r_idx     <= '0;
`ifdef UART_RX_PARITY_EN
                     r_par_bad <= 1'b0;
`endif
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == c_bit_end) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rx_s, r_shift[7:1]};
                  if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (r_cnt == c_bit_end) begin
                  r_cnt     <= '0;
                  r_par_bad <= w_rx_s ^ (^r_shift);
                  r_state   <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (r_cnt == c_bit_end) begin
                  r_cnt <= '0;
                  if (w_rx_s) begin
                     r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                     if (r_par_bad) begin
                        parity_err <= 1'b1;
                     end else begin
                        incoming <= r_shift;
                        valid    <= 1'b1;
                     end
`else
                     incoming <= r_shift;
                     valid    <= 1'b1;
`endif
                  end else begin
                     frame_err <= 1'b1;
                     r_state   <= S_WAIT_HIGH;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            // Hold off during a break so a long low line cannot look like a start.
            S_WAIT_HIGH: begin
               if (w_rx_s) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
